// File: rtl/adder_subtractor_multiword_serial_binary.sv
// Narrow combinational add/subtract with carry (add) or borrow (sub) in and out.
module Adder_Subtractor_Binary #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  add_sub,
  input  logic                  carry_in,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  carry_out
);

  logic [WORD_WIDTH:0] res;

  // One extra bit: for subtraction it goes to 1 exactly when the result is negative (a borrow).
  always_comb begin
    if (add_sub) res = {1'b0, a} - {1'b0, b} - {{WORD_WIDTH{1'b0}}, carry_in};
    else         res = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, carry_in};
  end

  assign sum       = res[WORD_WIDTH-1:0];
  assign carry_out = res[WORD_WIDTH];

endmodule

// File: rtl/adder_subtractor_multiword_serial.sv
// Word-serial multi-precision add/subtract. It feeds one narrow adder one chunk per cycle,
// least-significant chunk first, and chains the carry or borrow through a register.
module adder_subtractor_multiword_serial #(
  parameter  int WORD_WIDTH  = 8,
  parameter  int WORD_COUNT  = 4,
  localparam int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic                   add_sub,
  input  logic                   carry_in,
  input  logic [TOTAL_WIDTH-1:0] A_in,
  input  logic [TOTAL_WIDTH-1:0] B_in,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [TOTAL_WIDTH-1:0] sum_out,
  output logic                   carry_out,
  output logic                   overflow_out
);

  localparam int CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int SHIFT = TOTAL_WIDTH - WORD_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TOTAL_WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                   op_q, op_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WORD_WIDTH-1:0]  add_sum;
  logic                   add_co, last, a_top, b_top, r_top;

  Adder_Subtractor_Binary #(.WORD_WIDTH(WORD_WIDTH)) u_add (
    .a        (a_q[WORD_WIDTH-1:0]),
    .b        (b_q[WORD_WIDTH-1:0]),
    .add_sub  (op_q),
    .carry_in (carry_q),
    .sum      (add_sum),
    .carry_out(add_co)
  );

  assign last  = (cnt_q == CNT_W'(WORD_COUNT - 1));
  assign a_top = a_q[WORD_WIDTH-1];
  assign b_top = b_q[WORD_WIDTH-1];
  assign r_top = add_sum[WORD_WIDTH-1];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (input_valid) state_d = S_RUN;
      S_RUN:   if (last)        state_d = S_DONE;
      S_DONE:  if (output_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    op_d    = op_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: if (input_valid) begin
        a_d     = A_in;
        b_d     = B_in;
        op_d    = add_sub;
        carry_d = carry_in;
        cnt_d   = '0;
      end
      S_RUN: begin
        a_d     = a_q >> WORD_WIDTH;
        b_d     = b_q >> WORD_WIDTH;
        sum_d   = (sum_q >> WORD_WIDTH) | (TOTAL_WIDTH'(add_sum) << SHIFT);
        carry_d = add_co;
        // The counter stops at the last chunk so it never wraps.
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
        if (last) begin
          cout_d = add_co;
          // Subtraction overflows like an addition of ~B, so the sign of B is inverted.
          ovf_d  = (op_q ? (a_top != b_top) : (a_top == b_top)) && (r_top != a_top);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    input_ready  = (state_q == S_IDLE);
    output_valid = (state_q == S_DONE);
    sum_out      = sum_q;
    carry_out    = cout_q;
    overflow_out = ovf_q;
  end

endmodule
